// File: rtl/mem_sum_sequencer_pkg.sv
// Shared types and sizing constants for the memory pair-sum sequencer.
// The default geometry is 16 words of 8 bits, walked as 8 address pairs, with a 12-bit total.
package mem_sum_sequencer_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_M = 8;
    localparam int DEF_S = 12;

    localparam int MEM_DEPTH  = 2 ** DEF_N;
    localparam int PAIR_COUNT = 2 ** (DEF_N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int pair_count(input int n);
        return 2 ** (n - 1);
    endfunction

endpackage

// File: rtl/mem_sum_sequencer_if.sv
// Sequencer-side bundle: run request, dual combinational read port, status and result.
// master = sequencer, slave = memory/top-level environment.
interface mem_sum_sequencer_if #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int S = 12
);
    logic         start;
    logic [N-1:0] readAddr1;
    logic [N-1:0] readAddr2;
    logic [M-1:0] readData1;
    logic [M-1:0] readData2;
    logic         busy;
    logic         done;
    logic [S-1:0] sum;

    modport master (
        input  start, readData1, readData2,
        output readAddr1, readAddr2, busy, done, sum
    );

    modport slave (
        output start, readData1, readData2,
        input  readAddr1, readAddr2, busy, done, sum
    );
endinterface

// File: rtl/mem_sum_sequencer.sv
// Sweeps memory two words per cycle on start and totals them; done pulses 2^(N-1)+1 cycles after start.
// start is ignored while busy; no backpressure, the memory read is combinational.
module mem_sum_sequencer
    import mem_sum_sequencer_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int M = DEF_M,
    parameter int S = DEF_S
) (
    input  logic                clk,
    input  logic                reset,
    mem_sum_sequencer_if.master bus
);

    localparam int              PW        = N - 1;
    localparam logic [PW-1:0]   LAST_PAIR = PW'(pair_count(N) - 1);

    seq_state_t     r_state;
    logic [PW-1:0]  r_pair;
    logic [S-1:0]   r_acc;
    logic [S-1:0]   r_sum;
    logic           r_done;
    logic           r_busy;

    logic [S-1:0]   w_pair_sum;
    logic [S-1:0]   w_acc_next;
    logic           w_last_pair;

    // Operands are zero-extended; the total wraps modulo 2^S.
    assign w_pair_sum  = S'(bus.readData1) + S'(bus.readData2);
    assign w_acc_next  = r_acc + w_pair_sum;
    assign w_last_pair = (r_pair == LAST_PAIR);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pair  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= READ;
                        r_pair  <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                READ: begin
                    r_acc  <= w_acc_next;
                    r_pair <= r_pair + 1'b1;
                    // The counter wraps to 0 on the same edge that exits the sweep.
                    if (w_last_pair) begin
                        r_sum   <= w_acc_next;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.readAddr1 = (r_state == READ) ? {r_pair, 1'b0} : '0;
    assign bus.readAddr2 = (r_state == READ) ? {r_pair, 1'b1} : N'(1);
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;

endmodule

// File: tb/tb_mem_sum_sequencer.sv
// Directed bench for mem_sum_sequencer: vector table of memory fills plus reset/start corner sequences.
module tb_mem_sum_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_sum_sequencer_if #(.N(4), .M(8), .S(12)) bus ();

    logic [7:0] mem [16];
    assign bus.readData1 = mem[bus.readAddr1];
    assign bus.readData2 = mem[bus.readAddr2];

    mem_sum_sequencer #(.N(4), .M(8), .S(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // kind 0: all words = val; kind 1: mem[i] = i; kind 2: even words = val, odd words = 0
    typedef struct {
        int          kind;
        logic [7:0]  val;
        logic [11:0] exp_sum;
        bit          extra_start;
        string       tag;
    } vec_t;

    vec_t vecs [6];
    logic [11:0] exp_prev;

    task automatic fill(input int kind, input logic [7:0] val);
        for (int i = 0; i < 16; i++) begin
            if (kind == 0)      mem[i] = val;
            else if (kind == 1) mem[i] = 8'(i);
            else                mem[i] = (i % 2 == 0) ? val : 8'h00;
        end
    endtask

    // Pulses start for one cycle (cycle T) then observes cycles T+1..T+14.
    task automatic run_sweep(input logic [11:0] exp_sum, input logic [11:0] prev_sum,
                             input bit extra, input string tag);
        int dones   = 0;
        int done_at = -1;
        int busy_n  = 0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) begin
                @(negedge clk);
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                done_at = k;
            end
            if (bus.busy) busy_n++;
            if (k <= 8) begin
                chk({tag, " addr1"}, 32'(bus.readAddr1), 32'(2 * (k - 1)));
                chk({tag, " addr2"}, 32'(bus.readAddr2), 32'(2 * (k - 1) + 1));
                chk({tag, " sum_hold"}, 32'(bus.sum), 32'(prev_sum));
            end
            if (k == 9) chk({tag, " sum_at_done"}, 32'(bus.sum), 32'(exp_sum));
            if (extra && (k == 3 || k == 9)) bus.start = 1'b1;
        end
        chk({tag, " done_count"}, 32'(dones), 32'd1);
        chk({tag, " done_cycle"}, 32'(done_at), 32'd9);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd9);
        chk({tag, " sum_final"}, 32'(bus.sum), 32'(exp_sum));
        chk({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " idle_addr1"}, 32'(bus.readAddr1), 32'd0);
        chk({tag, " idle_addr2"}, 32'(bus.readAddr2), 32'd1);
    endtask

    initial begin
        vecs[0] = '{0, 8'h33, 12'h330, 1'b0, "all33"};
        vecs[1] = '{0, 8'hFF, 12'hFF0, 1'b0, "allFF"};
        vecs[2] = '{1, 8'h00, 12'h078, 1'b0, "ramp"};
        vecs[3] = '{0, 8'h00, 12'h000, 1'b0, "zero"};
        vecs[4] = '{2, 8'hAA, 12'h550, 1'b0, "evenAA"};
        vecs[5] = '{0, 8'h01, 12'h010, 1'b1, "restart_ignored"};

        bus.start = 1'b0;
        reset     = 1'b1;
        fill(0, 8'h00);
        repeat (2) @(negedge clk);
        chk("reset busy",  32'(bus.busy),      32'd0);
        chk("reset done",  32'(bus.done),      32'd0);
        chk("reset sum",   32'(bus.sum),       32'd0);
        chk("reset addr1", 32'(bus.readAddr1), 32'd0);
        chk("reset addr2", 32'(bus.readAddr2), 32'd1);
        reset = 1'b0;
        exp_prev = 12'h000;

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].kind, vecs[v].val);
            run_sweep(vecs[v].exp_sum, exp_prev, vecs[v].extra_start, vecs[v].tag);
            exp_prev = vecs[v].exp_sum;
        end

        // Reset in READ cycle 4 aborts the sweep after sum=0x330.
        fill(0, 8'h33);
        run_sweep(12'h330, exp_prev, 1'b0, "pre_abort");
        fill(0, 8'hFF);
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            chk("abort sum_hold", 32'(bus.sum),  32'h330);
            chk("abort busy_on",  32'(bus.busy), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy",  32'(bus.busy),      32'd0);
        chk("abort done",  32'(bus.done),      32'd0);
        chk("abort sum",   32'(bus.sum),       32'd0);
        chk("abort addr1", 32'(bus.readAddr1), 32'd0);
        chk("abort addr2", 32'(bus.readAddr2), 32'd1);
        begin
            int stray = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (bus.done || bus.busy) stray++;
            end
            chk("abort no_done", 32'(stray), 32'd0);
            chk("abort sum_kept", 32'(bus.sum), 32'd0);
        end
        run_sweep(12'hFF0, 12'h000, 1'b0, "after_abort");

        // reset and start together in IDLE: stays idle.
        @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst_start busy", 32'(bus.busy), 32'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst_start busy_after", 32'(bus.busy),      32'd0);
        chk("rst_start done_after", 32'(bus.done),      32'd0);
        chk("rst_start addr1",      32'(bus.readAddr1), 32'd0);
        chk("rst_start sum",        32'(bus.sum),       32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
